// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock/tick divider.
package clkdiv_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int unsigned MIN_DIV     = 2;
  localparam int unsigned DEF_CNT_W   = 26;
  localparam int unsigned DEF_DIV_VAL = 50000000;

  // High time of a square period: ceil(d/2).
  function automatic logic [31:0] ceil_half(input logic [31:0] d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, active/pending divisor and registered outputs.
import clkdiv_pkg::*;

module clkdiv_channel #(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = DEF_DIV_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             upd_pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] d;
  logic [CNT_W-1:0] h;
  logic             wrap;
  logic             boundary;
  mode_e            cur_mode;

  assign cur_mode = mode_e'(mode);

  always_comb begin
    d        = (active < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : active;
    h        = CNT_W'(ceil_half(32'(d)));
    wrap     = (cnt == d - CNT_W'(1));
    boundary = !en || wrap || sync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      active   <= CNT_W'(DEF_DIV);
      pend     <= CNT_W'(DEF_DIV);
      upd_pend <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (!en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else begin
        tick    <= (cnt == '0);
        clk_out <= (cur_mode == MODE_PULSE) ? (cnt == '0) : (cnt < h);
        cnt     <= (sync || wrap) ? '0 : cnt + CNT_W'(1);
      end

      // A divisor only becomes active at a boundary, so the running period keeps its length.
      if (load) begin
        pend <= div_val;
        if (boundary) begin
          active   <= div_val;
          upd_pend <= 1'b0;
        end else begin
          upd_pend <= 1'b1;
        end
      end else if (upd_pend && boundary) begin
        active   <= pend;
        upd_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock/tick generator: per-channel slicing plus shared sync.
import clkdiv_pkg::*;

module prog_clock_divider #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned DEF_DIV = DEF_DIV_VAL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       upd_pend
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .mode     (mode[i]),
      .load     (load[i]),
      .div_val  (div_val[i*CNT_W +: CNT_W]),
      .sync     (sync),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .upd_pend (upd_pend[i])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Table-driven bench for prog_clock_divider with a queue scoreboard of expected outputs.
module tb_prog_clock_divider;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DEF_DIV = 10;
  localparam int unsigned WD_CYCLES = 2000;

  logic                    clk;
  logic                    rst;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic                    sync;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       upd_pend;
  logic                    done;

  prog_clock_divider #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .div_val  (div_val),
    .sync     (sync),
    .clk_out  (clk_out),
    .tick     (tick),
    .upd_pend (upd_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] en;
    logic [1:0] mode;
    logic [1:0] load;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sync;
    logic [1:0] exp_clk;
    logic [1:0] exp_tick;
    logic [1:0] exp_pend;
    string      name;
  } vec_t;

  typedef struct {
    logic [1:0] clk;
    logic [1:0] tick;
    logic [1:0] pend;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic r, input logic [1:0] e, input logic [1:0] m,
                              input logic [1:0] l, input logic [7:0] a, input logic [7:0] b,
                              input logic s, input logic [1:0] c, input logic [1:0] t,
                              input logic [1:0] p, input string n);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.load = l; v.d0 = a; v.d1 = b; v.sync = s;
    v.exp_clk = c; v.exp_tick = t; v.exp_pend = p; v.name = n;
    vecs.push_back(v);
  endfunction

  // Free-running ch0 from phase 0 with ch1 disabled; expected waveform from phase arithmetic.
  function automatic void add_periodic(input logic m, input int unsigned dv,
                                       input int unsigned n, input string name);
    for (int unsigned k = 0; k < n; k++) begin
      int unsigned ph;
      logic c;
      logic t;
      ph = k % dv;
      t  = (ph == 0);
      c  = m ? t : (ph < (dv + 1) / 2);
      add(1'b0, 2'b01, {1'b0, m}, 2'b00, 8'd0, 8'd0, 1'b0, {1'b0, c}, {1'b0, t}, 2'b00, name);
    end
  endfunction

  initial begin
    done = 1'b0;
    for (int unsigned w = 0; w < WD_CYCLES; w++) begin
      @(posedge clk);
      if (done) break;
    end
    if (!done) begin
      errors++;
      $display("FAIL watchdog: vector run did not complete within %0d cycles", WD_CYCLES);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; en = '0; mode = '0; load = '0; div_val = '0; sync = 1'b0;

    @(posedge clk);
    #1;
    checks++;
    if (clk_out !== '0 || tick !== '0 || upd_pend !== '0) begin
      errors++;
      $display("FAIL reset_state: clk_out=%b tick=%b upd_pend=%b, expected all zero",
               clk_out, tick, upd_pend);
    end
    @(negedge clk);

    // Reset, then D=4 square starting on the first enabled edge.
    add(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "reset");
    add(0, 2'b00, 2'b00, 2'b01, 4, 0, 0, 2'b00, 2'b00, 2'b00, "ld4_dis");
    add_periodic(1'b0, 4, 9, "sq_d4");
    // D=5 square, then divisors 0 and 1 clamp to 2.
    add(0, 2'b00, 2'b00, 2'b01, 5, 0, 0, 2'b00, 2'b00, 2'b00, "ld5");
    add_periodic(1'b0, 5, 10, "sq_d5");
    add(0, 2'b00, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b00, "ld0");
    add_periodic(1'b0, 2, 4, "clamp_d0");
    add(0, 2'b00, 2'b00, 2'b01, 1, 0, 0, 2'b00, 2'b00, 2'b00, "ld1");
    add_periodic(1'b0, 2, 4, "clamp_d1");
    // Pulse D=3, then switch to square with cnt=1.
    add(0, 2'b00, 2'b01, 2'b01, 3, 0, 0, 2'b00, 2'b00, 2'b00, "ld3");
    add_periodic(1'b1, 3, 7, "pulse_d3");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00, "mode_sw1");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "mode_sw2");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b01, 2'b00, "mode_sw3");
    // D=8 running; load 3 at cnt=2, overwrite with 6 before the wrap.
    add(0, 2'b00, 2'b00, 2'b01, 8, 0, 0, 2'b00, 2'b00, 2'b00, "ld8");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b01, 2'b00, "e_c0");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00, "e_c1");
    add(0, 2'b01, 2'b00, 2'b01, 3, 0, 0, 2'b01, 2'b00, 2'b01, "e_ld3");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b01, "e_c3");
    add(0, 2'b01, 2'b00, 2'b01, 6, 0, 0, 2'b00, 2'b00, 2'b01, "e_ld6");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b01, "e_c5");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b01, "e_c6");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "e_wrap8");
    add_periodic(1'b0, 6, 5, "e_d6");
    add(0, 2'b01, 2'b00, 2'b01, 3, 0, 0, 2'b00, 2'b00, 2'b00, "e_ld_at_wrap");
    add_periodic(1'b0, 3, 4, "e_d3");
    // Two channels D=4/D=6, staggered enable, pending ch1 load applied by sync.
    add(0, 2'b00, 2'b00, 2'b11, 4, 6, 0, 2'b00, 2'b00, 2'b00, "f_ld");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b01, 2'b00, "f1");
    add(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00, "f2");
    add(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b10, 2'b10, 2'b00, "f3");
    add(0, 2'b11, 2'b00, 2'b10, 0, 2, 0, 2'b10, 2'b00, 2'b10, "f4_ld2");
    add(0, 2'b11, 2'b00, 2'b00, 0, 0, 1, 2'b11, 2'b01, 2'b00, "f5_sync");
    add(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b11, 2'b11, 2'b00, "f6_both_tick");
    add(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2'b00, "f7");
    add(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b10, 2'b10, 2'b00, "f8");
    // Reset mid-period with a load pending; DEF_DIV must come back.
    add(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "g0");
    add(0, 2'b11, 2'b00, 2'b01, 7, 0, 0, 2'b11, 2'b11, 2'b01, "g1_ld7");
    add(1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "g2_rst_mid");
    for (int unsigned i = 0; i < 3; i++)
      add(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, "g_dis");
    add_periodic(1'b0, DEF_DIV, 11, "def_div");

    foreach (vecs[i]) begin
      exp_t e;
      exp_t got_e;
      rst     = vecs[i].rst;
      en      = vecs[i].en;
      mode    = vecs[i].mode;
      load    = vecs[i].load;
      div_val = {vecs[i].d1, vecs[i].d0};
      sync    = vecs[i].sync;
      e.clk = vecs[i].exp_clk; e.tick = vecs[i].exp_tick;
      e.pend = vecs[i].exp_pend; e.name = vecs[i].name;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got_e = sb_q.pop_front();
      checks++;
      if (clk_out !== got_e.clk || tick !== got_e.tick || upd_pend !== got_e.pend) begin
        errors++;
        $display("FAIL %s (vec %0d): clk_out=%b tick=%b upd_pend=%b, expected %b %b %b",
                 got_e.name, i, clk_out, tick, upd_pend, got_e.clk, got_e.tick, got_e.pend);
      end
      @(negedge clk);
    end

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
Multi-channel programmable clock/tick generator. It is the parametrised successor of the single power-of-two bit-select divider. Each channel divides the system clock by an arbitrary integer D and emits either a 50%-duty square wave or a one-cycle enable pulse. Divisor updates are glitch-free: a new value takes effect only at a period boundary. A global sync strobe phase-aligns all channels. The block sits beside the controller core and supplies slow strobes (blink, debounce, baud) from the 50 MHz clock.

Parameters:
NUM_CH, 2, number of independent divider channels (1..8)
CNT_W, 26, divisor/counter width; 26 covers 50 MHz down to 1 Hz
DEF_DIV, 50000000, divisor loaded into every channel at reset (truncated to CNT_W)

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
en  input  NUM_CH  per-channel enable
mode  input  NUM_CH  per-channel output mode: 0 = square, 1 = pulse
load  input  NUM_CH  per-channel strobe; captures that channel's slice of div_val
div_val  input  NUM_CH*CNT_W  packed divisors; channel i uses bits [i*CNT_W +: CNT_W]
sync  input  1  global phase-realign strobe
clk_out  output  NUM_CH  divided output per channel (registered)
tick  output  NUM_CH  one-cycle pulse at the start of each period (registered)
upd_pend  output  NUM_CH  high while a loaded divisor is waiting for a boundary

Behaviour:
- Reset (rst=1 at an edge):
  - cnt=0, active=DEF_DIV, pend=DEF_DIV.
  - clk_out=0, tick=0, upd_pend=0 on all channels.
  - rst has priority over every other input.
- Effective divisor: D = max(active, 2). Values 0 and 1 are clamped to 2. High time H = D - (D>>1), i.e. ceil(D/2).
- Per enabled channel, each edge:
  - cnt <= (cnt == D-1) ? 0 : cnt+1
  - tick <= (cnt == 0)
  - square mode: clk_out <= (cnt < H)
  - pulse mode: clk_out <= (cnt == 0), identical to tick
- Timing: after the first enabled edge, output is high for H cycles and low for D-H cycles, period D. tick coincides with each clk_out rising edge. Latency from en rising to first tick/clk_out high is 1 cycle.
- Disabled channel (en=0):
  - cnt <= 0, clk_out <= 0, tick <= 0.
  - Re-enabling restarts the same phase deterministically.
- Divisor load:
  - load[i]=1 captures div_val slice into pend and sets upd_pend.
  - A later load before the boundary overwrites pend; the last one wins.
  - pend is copied to active, and upd_pend cleared, on the first edge where any of these holds: the channel is disabled; cnt == D-1 (the wrap edge); or sync=1.
  - load coinciding with the wrap, en=0, or sync: the new div_val goes straight to active and upd_pend stays 0.
  - No period is ever shortened or lengthened by a load; the period containing the load completes with the old D.
- sync=1:
  - Every enabled channel gets cnt <= 0, with outputs computed from the pre-sync cnt that cycle.
  - The next edge produces tick on all enabled channels simultaneously.
  - sync overrides wrap.
- mode change mid-period: takes effect on the next edge. No counter disturbance.
- Channels are fully independent apart from the shared sync.

Decomposition:
- Package clkdiv_pkg holds:
  - mode constants MODE_SQUARE=0 and MODE_PULSE=1
  - MIN_DIV=2
  - default CNT_W and DEF_DIV
  - a helper for the high time (ceil half)
- Sub-module clkdiv_channel holds one channel's cnt/active/pend/output registers. It is instantiated NUM_CH times in a generate loop. The top contains only slicing and the sync fan-out.

Test Plan:
- Reset release, load ch0 with 4, en=1, square mode → clk_out 1,1,0,0 repeating from the first enabled edge; tick at edges 1, 5, 9.
- D=5, square mode → high 3 cycles, low 2 cycles. div_val=0 or 1 → behaves as D=2: toggles every cycle, tick every 2 edges.
- Pulse mode, D=3 → clk_out equals tick, high exactly 1 of every 3 cycles. Switching to square mid-period changes output on the next edge with no extra tick.
- Running D=8, load 3 at cnt=2 → upd_pend high until the wrap edge. The current period stays 8 cycles, the next periods are 3. A second load of 6 before the wrap means 6 is used.
- Two channels, D=4 and D=6, desynchronised by staggered en; pulse sync → both tick on the same edge afterwards. A pending load is applied at the sync edge.
- rst asserted mid-period with load pending → all outputs 0 the next cycle, upd_pend=0, divisor back to DEF_DIV. en low for 3 cycles then high → tick on the first re-enabled edge.
